// File: rtl/pe_op_sequencer.sv
// Op sequencer for the 16-lane PE: steps Sel_cu / Sel_cu_go_back / Sel_adder / Is_save_cu_out
// through the fixed per-op step table, with start/busy/done handshake and abort.
module pe_op_sequencer #(
  parameter int unsigned STEP_CYCLES = 10,
  parameter int unsigned LAST_CYCLES = 20,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] step_idx,
  output logic [1:0] sel_cu,
  output logic [1:0] sel_cu_go_back,
  output logic [1:0] sel_adder,
  output logic       is_save_cu_out
);

  localparam logic [1:0] OpDot  = 2'b00;
  localparam logic [1:0] OpDist = 2'b10;
  localparam logic [1:0] OpIll  = 2'b11;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_lim;
  logic [2:0]       last_step;
  logic             done_d, err_d;
  logic [6:0]       ctrl_q, ctrl_d;

  // Packed as {sel_cu, sel_cu_go_back, sel_adder, is_save_cu_out}.
  function automatic logic [6:0] step_ctrl(input logic [1:0] o, input logic [2:0] s);
    logic [6:0] c;
    c = '0;
    if (o == OpDist) begin
      unique case (s)
        3'd0: c = 7'b00_00_00_0;
        3'd1: c = 7'b00_00_00_1;
        3'd2: c = 7'b00_01_00_1;
        3'd3: c = 7'b00_11_00_1;
        3'd4: c = 7'b00_11_00_0;
        3'd5: c = 7'b11_11_00_0;
        3'd6: c = 7'b11_10_00_0;
        3'd7: c = 7'b11_10_10_0;
      endcase
    end else begin
      case (s)
        3'd0:    c = 7'b11_00_00_0;
        3'd1:    c = 7'b11_10_00_0;
        3'd2:    c = (o == OpDot) ? 7'b11_10_10_0 : 7'b11_10_01_0;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  assign last_step = (op_q == OpDist) ? 3'd7 : 3'd2;
  assign cnt_lim   = (step_q == last_step) ? CNT_W'(LAST_CYCLES - 1) : CNT_W'(STEP_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op != OpIll) begin
            state_d = StRun;
            op_d    = op;
            step_d  = 3'd0;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        // Abort also beats completion of the last step, so no done on abort.
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == cnt_lim) begin
          if (step_q == last_step) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
            cnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs are decoded from next state and registered, so they switch only at edges.
    ctrl_d = (state_d == StRun) ? step_ctrl(op_d, step_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      step_q   <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      step_idx <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      busy     <= (state_d == StRun);
      done     <= done_d;
      err      <= err_d;
      step_idx <= (state_d == StRun) ? step_d : 3'd0;
      ctrl_q   <= ctrl_d;
    end
  end

  assign {sel_cu, sel_cu_go_back, sel_adder, is_save_cu_out} = ctrl_q;

endmodule

// File: tb/tb_pe_op_sequencer.sv
// Bench for pe_op_sequencer: table-driven op runs, directed corner sequences and random
// stimulus, all checked every cycle against an elapsed-time model of the op schedule.
module tb_pe_op_sequencer;

  localparam int S = 4;
  localparam int L = 6;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [1:0] op;
  logic       busy, done, err;
  logic [2:0] step_idx;
  logic [1:0] sel_cu, sel_cu_go_back, sel_adder;
  logic       is_save_cu_out;

  always #5 clk = ~clk;

  pe_op_sequencer #(
    .STEP_CYCLES(S),
    .LAST_CYCLES(L),
    .CNT_W      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .step_idx      (step_idx),
    .sel_cu        (sel_cu),
    .sel_cu_go_back(sel_cu_go_back),
    .sel_adder     (sel_adder),
    .is_save_cu_out(is_save_cu_out)
  );

  int total = 0;
  int bad   = 0;
  string phase = "reset";

  // Model: an op is "active" for a fixed number of cycles counted from its start edge.
  bit m_active, m_done, m_err;
  int m_op, m_t;
  logic [6:0] tab_dot[3], tab_elem[3], tab_dist[8];

  function automatic int n_steps(input int o);
    return (o == 2) ? 8 : 3;
  endfunction

  function automatic int op_len(input int o);
    return (n_steps(o) - 1) * S + L;
  endfunction

  function automatic logic [12:0] model_out();
    int st;
    logic [6:0] sel;
    if (!m_active) return {1'b0, m_done, m_err, 10'b0};
    st = (m_t < (n_steps(m_op) - 1) * S) ? m_t / S : n_steps(m_op) - 1;
    if (m_op == 0)      sel = tab_dot[st];
    else if (m_op == 1) sel = tab_elem[st];
    else                sel = tab_dist[st];
    return {1'b1, 1'b0, 1'b0, 3'(st), sel};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (%s) t=%0t: got %h, expected %h", name, phase, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic [1:0] o, input logic a, input logic r);
    logic [12:0] act;
    start = s;
    op    = o;
    abort = a;
    rst   = r;
    @(posedge clk);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (r) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (a) begin
        m_active = 1'b0;
      end else begin
        m_t++;
        if (m_t == op_len(m_op)) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (s) begin
      if (o == 2'b11) begin
        m_err = 1'b1;
      end else begin
        m_active = 1'b1;
        m_op     = int'(o);
        m_t      = 0;
      end
    end
    #1;
    act = {busy, done, err, step_idx, sel_cu, sel_cu_go_back, sel_adder, is_save_cu_out};
    check("cycle", 32'(act), 32'(model_out()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [1:0] op;
    int         exp_busy;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int busy_n, done_n, err_n;
    logic       rs, ss, as;
    logic [1:0] os;

    tab_dot  = '{7'b11_00_00_0, 7'b11_10_00_0, 7'b11_10_10_0};
    tab_elem = '{7'b11_00_00_0, 7'b11_10_00_0, 7'b11_10_01_0};
    tab_dist = '{7'b00_00_00_0, 7'b00_00_00_1, 7'b00_01_00_1, 7'b00_11_00_1,
                 7'b00_11_00_0, 7'b11_11_00_0, 7'b11_10_00_0, 7'b11_10_10_0};
    vecs[0] = '{2'b00, 14, 1, 0};
    vecs[1] = '{2'b01, 14, 1, 0};
    vecs[2] = '{2'b10, 34, 1, 0};
    vecs[3] = '{2'b11, 0, 0, 1};
    m_active = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_op     = 0;
    m_t      = 0;

    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    idle(2);

    // Whole-op runs: busy length, done and err pulse counts.
    for (int v = 0; v < 4; v++) begin
      phase = $sformatf("vec%0d", v);
      cyc(1'b1, vecs[v].op, 1'b0, 1'b0);
      busy_n = int'(busy);
      done_n = int'(done);
      err_n  = int'(err);
      for (int i = 0; i < 40; i++) begin
        cyc(1'b0, 2'b00, 1'b0, 1'b0);
        busy_n += int'(busy);
        done_n += int'(done);
        err_n  += int'(err);
      end
      check("busy_len", 32'(busy_n), 32'(vecs[v].exp_busy));
      check("done_cnt", 32'(done_n), 32'(vecs[v].exp_done));
      check("err_cnt", 32'(err_n), 32'(vecs[v].exp_err));
    end

    phase = "start_while_busy";
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    idle(3);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    idle(14);

    phase = "abort_dist";
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    idle(5);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    idle(2);
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    idle(16);

    phase = "abort_idle";
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 1'b0);
    idle(13);
    // Abort on the final cycle of the last step: no done.
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    idle(2);

    phase = "reset_mid_op";
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    idle(8);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    idle(2);

    phase = "back_to_back";
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    idle(14);
    check("b2b_done", 32'(done), 32'd1);
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    check("b2b_s0", 32'({busy, step_idx, sel_cu}), 32'({1'b1, 3'd0, 2'b11}));
    idle(14);
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    idle(36);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      ss = ($urandom_range(0, 5) == 0);
      as = ($urandom_range(0, 39) == 0);
      os = 2'($urandom_range(0, 3));
      cyc(ss, os, as, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
